// File: rtl/mem_bus_master.sv
// -----------------------------------------------------------------------------
// mem_bus_master
//
// Arbitrates between an instruction-fetch port and a data port and runs one
// transaction at a time on a simple strobed memory bus with a shared
// bidirectional data line.
//
// Each transaction is a short fixed sequence of states:
//   read : IDLE -> RD1 -> RD2 -> ACK -> IDLE  (one read every 4 cycles)
//   write: IDLE -> WR  -> ACK -> IDLE         (one write every 3 cycles)
//
// Ports
//   clk, reset_n        clock and synchronous active-low reset
//   i_req, i_addr       fetch request and address (fetches are always reads)
//   i_rdata, i_ack      fetched word (held until the next fetch capture), done pulse
//   d_req, d_we         data request and direction (1 = write)
//   d_addr, d_wdata     data address and write word
//   d_rdata, d_ack      read word (held until the next data capture), done pulse
//   readM, writeM       memory read / write strobes (never high together)
//   address             memory address (0 whenever no access is on the bus)
//   data                shared memory data bus, driven only while writeM = 1
// -----------------------------------------------------------------------------
module mem_bus_master #(
    parameter int unsigned WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    // Instruction-fetch port
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ack,
    // Data port
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ack,
    // Memory bus
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRd1  = 3'd1,
        StRd2  = 3'd2,
        StWr   = 3'd3,
        StAck  = 3'd4
    } state_e;

    // Port identifiers used for the granted-port and last-grant registers.
    localparam logic PortFetch = 1'b0;
    localparam logic PortData  = 1'b1;

    state_e                 state_q, state_d;
    logic                   port_q, port_d;
    logic                   last_grant_q, last_grant_d;
    logic                   we_q, we_d;
    logic [WORD_SIZE-1:0]   addr_q, addr_d;
    logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
    logic [WORD_SIZE-1:0]   i_rdata_q, i_rdata_d;
    logic [WORD_SIZE-1:0]   d_rdata_q, d_rdata_d;
    logic                   grant_data;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            port_q       <= PortFetch;
            // Last grant starts as "fetch" so the data port wins the first tie.
            last_grant_q <= PortFetch;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic and arbitration
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        // On a tie the port that did not win last time is granted.
        grant_data   = d_req && (!i_req || (last_grant_q == PortFetch));

        case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    if (grant_data) begin
                        port_d  = PortData;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        we_d    = d_we;
                    end else begin
                        port_d  = PortFetch;
                        addr_d  = i_addr;
                        wdata_d = '0;
                        we_d    = 1'b0;
                    end
                    last_grant_d = grant_data ? PortData : PortFetch;
                    state_d      = (grant_data && d_we) ? StWr : StRd1;
                end
            end
            StRd1: begin
                state_d = StRd2;
            end
            StRd2: begin
                // Memory has had a full cycle to respond; capture at end of RD2.
                if (port_q == PortData) begin
                    d_rdata_d = data;
                end else begin
                    i_rdata_d = data;
                end
                state_d = StAck;
            end
            StWr: begin
                state_d = StAck;
            end
            StAck: begin
                // Requests are deliberately ignored here; the next grant waits
                // for the following IDLE edge.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Bus and handshake outputs (decoded from the current state only)
    // -------------------------------------------------------------------------
    always_comb begin
        readM   = 1'b0;
        writeM  = 1'b0;
        address = '0;
        i_ack   = 1'b0;
        d_ack   = 1'b0;

        case (state_q)
            StRd1, StRd2: begin
                readM   = 1'b1;
                address = addr_q;
            end
            StWr: begin
                writeM  = 1'b1;
                address = addr_q;
            end
            StAck: begin
                i_ack = (port_q == PortFetch);
                d_ack = (port_q == PortData);
            end
            default: begin
            end
        endcase
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

    // Only the write state drives the shared bus; memory owns it otherwise.
    assign data = writeM ? wdata_q : {WORD_SIZE{1'bz}};

    // -------------------------------------------------------------------------
    // Protocol properties
    // -------------------------------------------------------------------------
    a_strobes_exclusive: assert property (
        @(posedge clk) disable iff (!reset_n) !(readM && writeM)
    );

    a_acks_exclusive: assert property (
        @(posedge clk) disable iff (!reset_n) !(i_ack && d_ack)
    );

    a_ack_one_cycle: assert property (
        @(posedge clk) disable iff (!reset_n) (i_ack || d_ack) |=> !(i_ack || d_ack)
    );

endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 Parameter WORD_SIZE, default 16, word width of all data and address paths.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 i_req  input  1  instruction-fetch request; held high until i_ack seen.
REQ-005 i_addr  input  WORD_SIZE  fetch address; stable while i_req high.
REQ-006 i_rdata  output  WORD_SIZE  fetched word; valid while i_ack high.
REQ-007 i_ack  output  1  one-cycle fetch-complete pulse.
REQ-008 d_req  input  1  data-access request; held high until d_ack seen.
REQ-009 d_we  input  1  1 = write, 0 = read; stable while d_req high.
REQ-010 d_addr, d_wdata  input  WORD_SIZE each  data address / write word; stable while d_req high.
REQ-011 d_rdata  output  WORD_SIZE  read word; valid while d_ack high.
REQ-012 d_ack  output  1  one-cycle data-complete pulse (reads and writes).
REQ-013 readM, writeM  output  1 each  memory read / write strobes.
REQ-014 address  output  WORD_SIZE  memory address.
REQ-015 data  inout  WORD_SIZE  shared bidirectional memory data bus.

Function
REQ-016 FSM states SHALL be IDLE, RD1, RD2, WR, ACK; exactly one transaction in flight.
REQ-017 IDLE: no strobes; on edge with any request pending, grant one, latch its address/wdata/we and port id, go RD1 (read) or WR (write); no request stays IDLE.
REQ-018 Arbitration: single requester granted directly; both pending -> grant the port NOT granted last; last_grant register updates on every grant.
REQ-019 Fetches are always reads; d_we selects read/write for data port.
REQ-020 RD1: readM=1, address=latched address; next state RD2.
REQ-021 RD2: readM=1, address held; data bus sampled at end of RD2 into the granted port's rdata register; next state ACK.
REQ-022 WR: writeM=1, address=latched address, data driven with latched wdata; next state ACK.
REQ-023 ACK: ack=1 for granted port only, one cycle; requests ignored in ACK; next state IDLE.
REQ-024 Latency: read ack in 3rd cycle after grant edge; write ack in 2nd cycle after grant edge; back-to-back throughput = one read per 4 cycles, one write per 3 cycles.
REQ-025 data SHALL be driven only when writeM=1, high-Z otherwise; readM and writeM SHALL never be high together.
REQ-026 address SHALL be 0 in IDLE and ACK; i_rdata/d_rdata hold last captured value until next capture on that port.
REQ-027 Requester dropping req before ack: transaction still completes and ack still pulses; no abort path.

Reset
REQ-028 reset_n low at edge: state=IDLE, readM=0, writeM=0, address=0, data high-Z, i_ack=d_ack=0, i_rdata=d_rdata=0, last_grant=fetch (data wins first tie).
REQ-029 Reset mid-transaction (any of RD1/RD2/WR/ACK): transaction dropped, no ack issued, strobes low in cycle following reset edge; memory contents unspecified for interrupted write.

Verification
REQ-030 Data write 0xBEEF to 0x0040 -> WR cycle writeM=1, address=0x0040, data=0xBEEF; d_ack 2 cycles after grant; then data read 0x0040 -> d_rdata=0xBEEF with d_ack 3 cycles after grant.
REQ-031 Fetch from 0x0040 after write above -> readM high exactly 2 cycles, i_rdata=0xBEEF, i_ack one cycle, d_ack stays 0.
REQ-032 i_req and d_req asserted same cycle right after reset -> data served first, fetch granted on IDLE edge after d_ack; both held continuously -> grants alternate d,i,d,i.
REQ-033 Bus check across mixed random sequence -> readM&writeM never 1; data high-Z whenever writeM=0 (bench drives via memory model only when readM=1).
REQ-034 reset_n low during RD2 -> no ack, readM=0 next cycle, FSM in IDLE; fresh read after reset returns correct word.
REQ-035 Requests held high through ACK -> no duplicate grant in ACK cycle; next grant only on following IDLE edge.
